// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the RV32I pipeline sequencing logic.
//   fwd_sel_t  : EX-stage operand source select (regfile / WB / MEM result).
//   hz_state_t : hazard controller sequencing state.
//   REG_ZERO   : architectural x0, never a forwarding or hazard source.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_BUSY = 2'b01,
    DISCARD  = 2'b10
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one EX-stage source operand. The MEM
// stage result is newer than the WB result, so it wins when both match.
// Ports:
//   rs_e        in  5  source register of the EX instruction
//   rd_m        in  5  destination register in MEM
//   reg_write_m in  1  MEM instruction writes the register file
//   rd_w        in  5  destination register in WB
//   reg_write_w in  1  WB instruction writes the register file
//   fwd_sel     out    selected operand source (fwd_sel_t)
// -----------------------------------------------------------------------------
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core. Produces the
// stall/flush enables for PC, IF/ID, ID/EX and EX/MEM and the EX forwarding
// selects. Sequences load-use bubbles, multi-cycle MDU operations (with a
// timeout) and instruction-memory wait states, including redirects that
// arrive while a fetch is still outstanding.
//
// Optional feature macro: HAZARD_PERF_EN
//   When defined, adds perf_clr (in) and stall_cycles (out), a saturating
//   count of cycles with StallF=1.
//
// Parameters:
//   MDU_TIMEOUT  max MDU_BUSY cycles before forced return to RUN (<= 128)
//   CNT_W        width of the stall performance counter
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   Rs1D, Rs2D                   sources of the ID instruction
//   Rs1E, Rs2E, RdE              sources/destination of the EX instruction
//   RdM, RdW, RegWriteM/W        destinations and write enables in MEM/WB
//   LoadE, PCSrcE, mdu_start_e   EX load / taken redirect / MDU op
//   mdu_done, imem_ready         MDU result valid, imem response this cycle
//   StallF, StallD, StallE       hold PC, IF/ID, ID/EX
//   FlushD, FlushE, FlushM       zero IF/ID, ID/EX, EX/MEM
//   ForwardAE, ForwardBE         00 regfile, 10 MEM, 01 WB
//   mdu_err                      registered one-cycle pulse after MDU timeout
//   perf_clr, stall_cycles       (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             mdu_start_e,
  input  logic             mdu_done,
  input  logic             imem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
`ifdef HAZARD_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             mdu_err
);

  localparam logic [6:0] CNT_LAST = 7'(MDU_TIMEOUT - 1);

  hz_state_t  state_d, state_q;
  logic [6:0] cnt_d, cnt_q;
  logic       mdu_err_d, mdu_err_q;
  logic       lu;
  fwd_sel_t   fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // The load result is not available until MEM, so an ID consumer of the
  // load destination must wait one bubble.
  assign lu = LoadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall/flush enables are combinational so a redirect or hazard acts in the
  // same cycle; only the sequencing state and mdu_err are registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_err_d = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (PCSrcE) begin
          // PC loads the target; an outstanding fetch must be discarded
          // when it finally returns.
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (!imem_ready) begin
            state_d = DISCARD;
          end
        end else if (mdu_start_e) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          state_d = MDU_BUSY;
          cnt_d   = '0;
        end else if (lu) begin
          // Holding ID also covers a concurrent fetch wait, so FlushD stays 0.
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (!imem_ready) begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end
      end

      MDU_BUSY: begin
        if (mdu_done) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          if (cnt_q == CNT_LAST) begin
            mdu_err_d = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end

      DISCARD: begin
        // The pending response belongs to the old path and is always dropped;
        // once it arrives the target fetch may issue.
        FlushD = 1'b1;
        if (imem_ready) begin
          state_d = RUN;
        end else begin
          StallF = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencing state; reset abandons any MDU operation without an error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mdu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdu_err_q <= mdu_err_d;
    end
  end

  assign mdu_err = mdu_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
